// File: rtl/fifo_flush_pkg.sv
// -----------------------------------------------------------------------------
// fifo_flush_pkg
// Shared definitions for the flushed-word nibble unpacker:
//   PAD_NIBBLE        default pad code filling unused upper nibbles
//   NIBBLES_PER_WORD  nibbles carried by one 32-bit flushed word
//   IDX_W             width of a nibble index within a word
//   state_t           output FSM states (IDLE, SHIFT)
//   entry_t           buffered word: {data, payload length}
// -----------------------------------------------------------------------------
package fifo_flush_pkg;

  localparam logic [3:0] PAD_NIBBLE       = 4'hC;
  localparam int         NIBBLES_PER_WORD = 8;
  localparam int         IDX_W            = $clog2(NIBBLES_PER_WORD);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  len;
  } entry_t;

endpackage

// File: rtl/flush_pad_len.sv
// -----------------------------------------------------------------------------
// flush_pad_len
// Combinational payload-length finder for a flushed word. Counts the run of
// pad nibbles starting at nibble 7 and walking down; the first non-pad nibble
// ends the run, so pad codes below real data stay part of the payload.
// Ports:
//   data  in  [31:0]  flushed word, nibble 0 in bits [3:0]
//   len   out [3:0]   payload length, 0..8
// -----------------------------------------------------------------------------
module flush_pad_len #(
  parameter logic [3:0] PAD_NIBBLE = 4'hC
) (
  input  logic [31:0] data,
  output logic [3:0]  len
);
  import fifo_flush_pkg::*;

  logic [3:0] run_s;
  logic       in_run_s;

  // Count leading (top-down) pad nibbles and derive the payload length.
  always_comb begin
    run_s    = 4'd0;
    in_run_s = 1'b1;
    for (int i = NIBBLES_PER_WORD - 1; i >= 0; i--) begin
      if (in_run_s && (data[4*i +: 4] == PAD_NIBBLE)) begin
        run_s = run_s + 4'd1;
      end else begin
        in_run_s = 1'b0;
      end
    end
    len = 4'(NIBBLES_PER_WORD) - run_s;
  end

endmodule

// File: rtl/flush_nibble_unpack.sv
// -----------------------------------------------------------------------------
// flush_nibble_unpack
// Buffers flushed 32-bit words (trailing pad stripped) and streams their
// payload nibbles out one per handshake, nibble 0 first.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   flush_valid_i  in   qualifier for flush_data_i
//   flush_data_i   in   [31:0] flushed word
//   flush_ready_o  out  buffer can take a word this cycle
//   nib_valid_o    out  nib_data_o valid
//   nib_data_o     out  [3:0] payload nibble
//   nib_ready_i    in   consumer accepts the nibble
//   nib_last_o     out  last payload nibble of its word
//   word_empty_o   out  one-cycle pulse: accepted word had no payload
//   overflow_o     out  sticky: word arrived while not ready
//   busy_o         out  buffer non-empty or shifting
// -----------------------------------------------------------------------------
module flush_nibble_unpack #(
  parameter logic [3:0] PAD_NIBBLE = 4'hC,
  parameter int         BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_valid_i,
  input  logic [31:0] flush_data_i,
  output logic        flush_ready_o,
  output logic        nib_valid_o,
  output logic [3:0]  nib_data_o,
  input  logic        nib_ready_i,
  output logic        nib_last_o,
  output logic        word_empty_o,
  output logic        overflow_o,
  output logic        busy_o
);
  import fifo_flush_pkg::*;

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  // Pointer increment wrapping modulo BUF_DEPTH (depth need not be 2^n).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  entry_t           mem_r [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nx_s;
  state_t           state_r, state_nx_s;
  logic [31:0]      shift_r, shift_nx_s;
  logic [IDX_W-1:0] idx_r, idx_nx_s;
  logic [3:0]       len_r, len_nx_s;
  logic             last_r, last_nx_s;
  logic             ready_r, empty_r, ovf_r, busy_r;
  logic [3:0]       pad_len_s;
  logic             accept_s, push_s, hs_s, pop_s;
  entry_t           head_s, next_s;

  flush_pad_len #(.PAD_NIBBLE(PAD_NIBBLE)) u_pad_len (
    .data (flush_data_i),
    .len  (pad_len_s)
  );

  assign head_s = mem_r[rd_ptr_r];
  assign next_s = mem_r[ptr_inc(rd_ptr_r)];

  // Handshake decode and next-state computation for buffer count and FSM.
  always_comb begin
    accept_s   = flush_valid_i && ready_r;
    push_s     = accept_s && (pad_len_s != 4'd0);
    hs_s       = (state_r == SHIFT) && nib_ready_i;
    pop_s      = hs_s && last_r;
    count_nx_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    state_nx_s = state_r;
    shift_nx_s = shift_r;
    idx_nx_s   = idx_r;
    len_nx_s   = len_r;
    last_nx_s  = last_r;
    case (state_r)
      IDLE: begin
        if (count_r != '0) begin
          state_nx_s = SHIFT;
          shift_nx_s = head_s.data;
          len_nx_s   = head_s.len;
          idx_nx_s   = '0;
          last_nx_s  = (head_s.len == 4'd1);
        end else begin
          last_nx_s  = 1'b0;
        end
      end
      SHIFT: begin
        if (hs_s && last_r) begin
          // Word done: chain straight into the next buffered word if present.
          if (count_r > CNT_W'(1)) begin
            shift_nx_s = next_s.data;
            len_nx_s   = next_s.len;
            idx_nx_s   = '0;
            last_nx_s  = (next_s.len == 4'd1);
          end else begin
            state_nx_s = IDLE;
            shift_nx_s = shift_r >> 4;
            last_nx_s  = 1'b0;
          end
        end else if (hs_s) begin
          shift_nx_s = shift_r >> 4;
          idx_nx_s   = idx_r + IDX_W'(1);
          last_nx_s  = ({1'b0, idx_r} + 4'd1) == (len_r - 4'd1);
        end else begin
          state_nx_s = SHIFT;
        end
      end
      default: begin
        state_nx_s = IDLE;
        last_nx_s  = 1'b0;
      end
    endcase
  end

  // Control state, shift register and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      state_r  <= IDLE;
      shift_r  <= 32'd0;
      idx_r    <= '0;
      len_r    <= 4'd0;
      last_r   <= 1'b0;
      ready_r  <= 1'b0;
      empty_r  <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nx_s;
      state_r <= state_nx_s;
      shift_r <= shift_nx_s;
      idx_r   <= idx_nx_s;
      len_r   <= len_nx_s;
      last_r  <= last_nx_s;
      // Ready looks only at the settled count: no pass-through from a pop.
      ready_r <= (count_nx_s < DEPTH_C);
      empty_r <= accept_s && (pad_len_s == 4'd0);
      ovf_r   <= ovf_r | (flush_valid_i & ~ready_r);
      busy_r  <= (count_nx_s != '0) || (state_nx_s == SHIFT);
    end
  end

  // Word storage written on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {flush_data_i, pad_len_s};
    end
  end

  assign flush_ready_o = ready_r;
  assign nib_valid_o   = (state_r == SHIFT);
  assign nib_data_o    = shift_r[3:0];
  assign nib_last_o    = last_r;
  assign word_empty_o  = empty_r;
  assign overflow_o    = ovf_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_flush_nibble_unpack.sv
// -----------------------------------------------------------------------------
// tb_flush_nibble_unpack
// Self-checking bench: a queue-based word/nibble model is compared against the
// DUT on every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_flush_nibble_unpack;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_valid;
  logic [31:0] flush_data;
  logic        flush_ready_o;
  logic        nib_valid_o;
  logic [3:0]  nib_data_o;
  logic        nib_ready;
  logic        nib_last_o;
  logic        word_empty_o;
  logic        overflow_o;
  logic        busy_o;

  flush_nibble_unpack #(.PAD_NIBBLE(4'hC), .BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .flush_valid_i (flush_valid),
    .flush_data_i  (flush_data),
    .flush_ready_o (flush_ready_o),
    .nib_valid_o   (nib_valid_o),
    .nib_data_o    (nib_data_o),
    .nib_ready_i   (nib_ready),
    .nib_last_o    (nib_last_o),
    .word_empty_o  (word_empty_o),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Payload length from the rule: strip pad nibbles from the top only.
  function automatic int payload_len(input logic [31:0] w);
    int n = 8;
    while (n > 0 && w[4*n-1 -: 4] == 4'hC) n--;
    return n;
  endfunction

  // Model state: words held (current included) and their nibbles in order.
  int         m_cnt;
  bit         m_shift, m_rdy, m_empty, m_ovf;
  logic [3:0] m_nibs[$];
  bit         m_last[$];

  // Observation logs for directed checks.
  logic [3:0] got_nib[$];
  bit         got_last[$];
  int         got_cyc[$];
  int         got_empty[$];
  bit         busy_seen;
  logic [3:0] exp_nib[$];
  bit         exp_last[$];

  task automatic clear_logs();
    got_nib.delete(); got_last.delete(); got_cyc.delete(); got_empty.delete();
    busy_seen = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: check DUT against the model, then advance the model
  // with the inputs that the next rising edge will sample.
  initial begin
    bit         prev_hold = 1'b0;
    logic [3:0] prev_data = 4'd0;
    logic       prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cnt = 0; m_shift = 0; m_rdy = 0; m_empty = 0; m_ovf = 0;
        m_nibs.delete(); m_last.delete();
        prev_hold = 1'b0;
        chk("rst ready", flush_ready_o, 0);
        chk("rst valid", nib_valid_o, 0);
        chk("rst data",  nib_data_o, 0);
        chk("rst last",  nib_last_o, 0);
        chk("rst empty", word_empty_o, 0);
        chk("rst ovf",   overflow_o, 0);
        chk("rst busy",  busy_o, 0);
      end else begin
        bit hs, pop, acc, nshift;
        int n;
        chk("ready", flush_ready_o, m_rdy);
        chk("valid", nib_valid_o, m_shift);
        chk("busy",  busy_o, (m_cnt != 0) || m_shift);
        chk("empty", word_empty_o, m_empty);
        chk("ovf",   overflow_o, m_ovf);
        if (m_shift && m_nibs.size() > 0) begin
          chk("data", nib_data_o, m_nibs[0]);
          chk("last", nib_last_o, m_last[0]);
        end
        if (prev_hold) begin
          chk("hold valid", nib_valid_o, 1);
          chk("hold data",  nib_data_o, prev_data);
          chk("hold last",  nib_last_o, prev_last);
        end
        prev_hold = nib_valid_o && !nib_ready;
        prev_data = nib_data_o;
        prev_last = nib_last_o;
        if (nib_valid_o && nib_ready) begin
          got_nib.push_back(nib_data_o);
          got_last.push_back(nib_last_o);
          got_cyc.push_back(cyc);
        end
        if (word_empty_o) got_empty.push_back(cyc);
        if (busy_o) busy_seen = 1'b1;
        // Advance the model across the coming edge.
        hs  = m_shift && nib_ready;
        pop = hs && (m_last.size() > 0) && m_last[0];
        if (hs && m_nibs.size() > 0) begin
          void'(m_nibs.pop_front());
          void'(m_last.pop_front());
        end
        if (!m_shift)  nshift = (m_cnt > 0);
        else if (pop)  nshift = (m_cnt > 1);
        else           nshift = 1'b1;
        acc = flush_valid && m_rdy;
        n   = payload_len(flush_data);
        if (pop) m_cnt--;
        if (acc && n > 0) begin
          m_cnt++;
          for (int i = 0; i < n; i++) begin
            m_nibs.push_back(flush_data[4*i +: 4]);
            m_last.push_back(i == n - 1);
          end
        end
        m_empty = acc && (n == 0);
        if (flush_valid && !m_rdy) m_ovf = 1'b1;
        m_rdy   = (m_cnt < DEPTH);
        m_shift = nshift;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] w);
    flush_valid = 1'b1;
    flush_data  = w;
    tick();
    flush_valid = 1'b0;
    flush_data  = 32'd0;
  endtask

  // Compare logged stream with exp_nib/exp_last; first_cyc<0 skips timing.
  task automatic check_stream(input string name, input int first_cyc);
    chk({name, " count"}, got_nib.size(), exp_nib.size());
    for (int i = 0; i < exp_nib.size() && i < got_nib.size(); i++) begin
      chk({name, " nib"},  got_nib[i],  exp_nib[i]);
      chk({name, " last"}, got_last[i], exp_last[i]);
      if (first_cyc >= 0) chk({name, " cyc"}, got_cyc[i], first_cyc + i);
    end
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; flush_valid = 1'b0; flush_data = 32'd0; nib_ready = 1'b0;
    clear_logs();

    // Model pins: payload length of the directed words.
    chk("len 4321", payload_len(32'hCCCC_4321), 4);
    chk("len C5C5", payload_len(32'hC5C5_C5C5), 7);
    chk("len CCCC", payload_len(32'hCCCC_CCCC), 0);
    chk("len 8765", payload_len(32'h8765_4321), 8);

    #2;
    chk("t0 ready", flush_ready_o, 0);
    chk("t0 valid", nib_valid_o, 0);
    chk("t0 busy",  busy_o, 0);
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("ready after release", flush_ready_o, 1);

    // Short word, latency and consecutive output.
    nib_ready = 1'b1;
    clear_logs();
    send(32'hCCCC_4321);
    n0 = cyc;
    ticks(8);
    exp_nib  = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_last = '{0, 0, 0, 1};
    check_stream("w4321", n0 + 1);

    // All-pad word: no nibbles, one empty pulse, never busy.
    clear_logs();
    send(32'hCCCC_CCCC);
    n0 = cyc;
    ticks(6);
    chk("allpad nibs", got_nib.size(), 0);
    chk("allpad pulses", got_empty.size(), 1);
    if (got_empty.size() > 0) chk("allpad pulse cyc", got_empty[0], n0);
    chk("allpad busy", busy_seen, 0);

    // Embedded pad codes survive; only the top run is stripped.
    clear_logs();
    send(32'hC5C5_C5C5);
    n0 = cyc;
    ticks(10);
    exp_nib  = '{4'h5, 4'hC, 4'h5, 4'hC, 4'h5, 4'hC, 4'h5};
    exp_last = '{0, 0, 0, 0, 0, 0, 1};
    check_stream("wC5C5", n0 + 1);

    // Fill while stalled, overflow on the third word, then gapless drain.
    nib_ready = 1'b0;
    clear_logs();
    send(32'h8765_4321);
    send(32'h8765_4321);
    chk("full ready", flush_ready_o, 0);
    send(32'h8765_4321);
    chk("overflow", overflow_o, 1);
    ticks(2);
    nib_ready = 1'b1;
    n0 = cyc;
    ticks(20);
    exp_nib.delete(); exp_last.delete();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        exp_nib.push_back(4'(i + 1));
        exp_last.push_back(i == 7);
      end
    end
    check_stream("burst", n0);
    chk("overflow sticky", overflow_o, 1);

    // Toggle ready every cycle mid-word.
    clear_logs();
    send(32'h8765_4321);
    for (int i = 0; i < 24; i++) begin
      nib_ready = ~nib_ready;
      tick();
    end
    nib_ready = 1'b1;
    ticks(4);
    exp_nib.delete(); exp_last.delete();
    for (int i = 0; i < 8; i++) begin
      exp_nib.push_back(4'(i + 1));
      exp_last.push_back(i == 7);
    end
    check_stream("toggle", -1);

    // Reset during the third nibble.
    nib_ready = 1'b1;
    send(32'h8765_4321);
    ticks(3);
    chk("pre-reset nib", nib_data_o, 4'h3);
    rst_n = 1'b0;
    #1;
    chk("mid rst ready", flush_ready_o, 0);
    chk("mid rst valid", nib_valid_o, 0);
    chk("mid rst data",  nib_data_o, 0);
    chk("mid rst last",  nib_last_o, 0);
    chk("mid rst empty", word_empty_o, 0);
    chk("mid rst ovf",   overflow_o, 0);
    chk("mid rst busy",  busy_o, 0);
    ticks(2);
    rst_n = 1'b1;
    clear_logs();
    tick();
    chk("re-release ready", flush_ready_o, 1);
    ticks(12);
    chk("no residual nibs", got_nib.size(), 0);
    chk("no residual busy", busy_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
